sram_dp_init: RTL and testbench
===============================

# sram_dp_init

Parametrised simple-dual-port SRAM with one write port and one read port on a single clock. It adds byte-enabled writes, a selectable 1- or 2-cycle read pipeline with a valid flag, write-first collision bypass, out-of-range detection and a sequential initialisation sweep. The sweep runs after reset or on request and replaces a single-cycle array clear. It is the general storage primitive for the block's datapath buffers.

## Interface
- ADDR_W, default 4: address width.
- DATA_W, default 8: word width; must be a multiple of 8.
- DEPTH, default 16: number of words; 2 ≤ DEPTH ≤ 2^ADDR_W.
- RD_LAT, default 1: read latency in cycles; legal values are 1 or 2.
- INIT_VAL, default 0: DATA_W-bit value written to every word by the sweep.

Ports (BE_W = DATA_W/8):
- clk  in  1  clock; all logic on the rising edge.
- wrst_n  in  1  reset, synchronous, active-low.
- chip_en  in  1  global enable; gates the read and write ports only, not the sweep.
- clr_req  in  1  single-cycle request to re-run the init sweep.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i controls wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds its last value while rd_valid=0.
- rd_valid  out  1  qualifies rd_data for exactly one cycle per accepted read.
- init_busy  out  1  high while the sweep runs; accesses are ignored.
- addr_err  out  1  one-cycle pulse for an access with address ≥ DEPTH.

## Operation
- The FSM has two states, INIT and READY.
- INIT:
  - A counter sweeps addresses 0..DEPTH-1, writing INIT_VAL to one word per cycle.
  - The FSM moves to READY in the cycle after address DEPTH-1 is written.
  - init_busy = 1 throughout INIT.
- READY: init_busy = 0. clr_req=1 moves the FSM to INIT with the counter at 0.
- clr_req has no effect during INIT; the sweep is not restarted.
- Accepted write: READY && chip_en && wr_en && wr_addr < DEPTH. Only bytes with wr_be[i]=1 change; wr_be=0 leaves the word unchanged.
- Accepted read: READY && chip_en && rd_en && rd_addr < DEPTH.
- Out-of-range access: in READY with chip_en=1, wr_addr ≥ DEPTH with wr_en=1, or rd_addr ≥ DEPTH with rd_en=1, pulses addr_err the next cycle. A bad write is dropped. A bad read produces no rd_valid.
- Collision is write-first: an accepted read and an accepted write to the same address in the same cycle return the post-write word. Enabled bytes come from wr_data; disabled bytes come from the array.
- Requests during INIT, or with chip_en=0, are ignored: no array change, no rd_valid, no addr_err.
- A clr_req accepted in READY in the same cycle as an accepted write:
  - The write is discarded.
  - A read in that same cycle is still accepted and returns pre-clear data.

## Timing
- Values in the cycle after wrst_n=0 is sampled:
  - FSM = INIT, counter = 0, init_busy = 1.
  - rd_valid = 0, rd_data = 0, addr_err = 0.
  - All read-pipeline stages are flushed.
- Reset asserted mid-sweep restarts the sweep at address 0.
- Reset asserted with reads in flight drops them; no rd_valid is produced for them.
- Sweep duration: init_busy is high for exactly DEPTH cycles after reset deassertion or after clr_req. The first access is accepted in cycle DEPTH.
- RD_LAT=1: a read accepted at edge N gives rd_data/rd_valid valid after edge N+1.
- RD_LAT=2: the extra output register gives valid data after edge N+2.
- Throughput is one read per cycle back-to-back; rd_valid stays high continuously.
- Reads accepted before clr_req complete normally through the pipeline during INIT.
- A write at edge N is visible to a read accepted at edge N (bypass) and to any later read.
- addr_err appears one cycle after the offending request, independent of RD_LAT.

## Test plan
- Reset sweep:
  - Stimulus: DEPTH=16, INIT_VAL=8'hA5; deassert wrst_n.
  - Response: init_busy high for 16 cycles.
  - Then read all 16 addresses: every read returns 8'hA5 and rd_valid pulses 16 times.
- Byte enables:
  - Stimulus: DATA_W=32; write 32'h11223344 to address 3 with wr_be=4'hF; then write 32'hAABBCCDD to address 3 with wr_be=4'b0101.
  - Response: a read of address 3 returns 32'h11BB33DD.
- Collision:
  - Stimulus: address 5 holds 8'h00; in the same cycle, write 8'h7E to address 5 and read address 5.
  - Response: rd_data = 8'h7E after RD_LAT cycles.
- Latency and streaming:
  - Stimulus: RD_LAT=2; rd_en high for 4 consecutive cycles on addresses 0..3.
  - Response: rd_valid is high on cycles N+2..N+5 with the data in address order.
- Out of range:
  - Stimulus: DEPTH=12, ADDR_W=4; write 8'h55 to address 13, then read address 13.
  - Response: addr_err pulses once for each request; no rd_valid; the array is unchanged.
- clr_req and reset mid-sweep:
  - Stimulus: assert clr_req; assert wrst_n=0 at sweep cycle 5.
  - Response: after reset deassertion, init_busy is high for the full DEPTH cycles.
  - Stimulus: send a write and a read during INIT.
  - Response: both are ignored, with no addr_err.

Source files
------------

// File: rtl/sram_dp_init.sv
// Simple-dual-port SRAM with byte-enabled writes, a 1- or 2-cycle read pipeline,
// write-first collision bypass, address range checking and a sequential init sweep.
module sram_dp_init #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  wrst_n,
    input  logic                  chip_en,
    input  logic                  clr_req,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  init_busy,
    output logic                  addr_err
);

    localparam int               BE_W      = DATA_W / 8;
    localparam logic [0:0]       ST_INIT   = 1'b0;
    localparam logic [0:0]       ST_READY  = 1'b1;
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] r_mem_q;
    logic [DATA_W-1:0] r_byp_data;
    logic [BE_W-1:0]   r_byp_be;
    logic              r_v1;
    logic              r_addr_err;

    logic              w_ready;
    logic              w_port_en;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_addr_bad;
    logic              w_collide;
    logic [DATA_W-1:0] w_s1_data;

    assign w_ready       = (r_state == ST_READY);
    assign w_port_en     = w_ready & chip_en;
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    // A clear request swallows a same-cycle write so the sweep starts from a clean slate.
    assign w_wr_acc      = w_port_en & wr_en & w_wr_in_range & ~clr_req;
    assign w_rd_acc      = w_port_en & rd_en & w_rd_in_range;
    assign w_addr_bad    = w_port_en & ((wr_en & ~w_wr_in_range) | (rd_en & ~w_rd_in_range));
    assign w_collide     = w_wr_acc & w_rd_acc & (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr_req) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is what gives it a defined content.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 1 keeps the raw array word plus the colliding write lanes; merged below.
    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            r_v1       <= 1'b0;
            r_mem_q    <= '0;
            r_byp_data <= '0;
            r_byp_be   <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_mem_q    <= r_mem[rd_addr];
                r_byp_data <= wr_data;
                r_byp_be   <= w_collide ? wr_be : '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            assign w_s1_data[8*gi +: 8] = r_byp_be[gi] ? r_byp_data[8*gi +: 8]
                                                       : r_mem_q[8*gi +: 8];
        end
    endgenerate

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rd_data2;
            logic              r_v2;

            always_ff @(posedge clk) begin
                if (!wrst_n) begin
                    r_v2       <= 1'b0;
                    r_rd_data2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_rd_data2 <= w_s1_data;
                    end
                end
            end

            assign rd_data  = r_rd_data2;
            assign rd_valid = r_v2;
        end else begin : g_lat1
            // Stage-1 registers only load on an accepted read, so the output holds.
            assign rd_data  = w_s1_data;
            assign rd_valid = r_v1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_addr_bad;
        end
    end

    assign addr_err  = r_addr_err;
    assign init_busy = (r_state == ST_INIT);

endmodule

// File: tb/tb_sram_dp_init.sv
// Drives two configurations of sram_dp_init (DEPTH 16/RD_LAT 1 and DEPTH 12/RD_LAT 2)
// with shared stimulus and checks both against a cycle-level behavioural model.
module tb_sram_dp_init;

    localparam int             AW = 4;
    localparam int             DW = 32;
    localparam logic [DW-1:0]  IV = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          wrst_n, chip_en, clr_req, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;

    logic [DW-1:0] rdata [2];
    logic          rvalid [2];
    logic          ibusy  [2];
    logic          aerr   [2];

    always #5 clk = ~clk;

    sram_dp_init #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .RD_LAT(1), .INIT_VAL(IV)) u_a (
        .clk(clk), .wrst_n(wrst_n), .chip_en(chip_en), .clr_req(clr_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdata[0]), .rd_valid(rvalid[0]),
        .init_busy(ibusy[0]), .addr_err(aerr[0])
    );

    sram_dp_init #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(12), .RD_LAT(2), .INIT_VAL(IV)) u_b (
        .clk(clk), .wrst_n(wrst_n), .chip_en(chip_en), .clr_req(clr_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdata[1]), .rd_valid(rvalid[1]),
        .init_busy(ibusy[1]), .addr_err(aerr[1])
    );

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string name, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, k, act, req, $time);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Behavioural model: array contents, remaining sweep cycles and a read delay line.
    logic [DW-1:0] m_mem [2][16];
    int            m_left [2];
    bit            m_v [2], m_err [2], m_pv [2];
    logic [DW-1:0] m_d [2], m_pd [2];
    bit            m_acc, m_rdy;
    logic [DW-1:0] m_val;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!wrst_n) begin
                m_left[k] = dep(k);
                m_v[k] = 0; m_err[k] = 0; m_pv[k] = 0;
                m_d[k] = '0; m_pd[k] = '0;
                for (int a = 0; a < 16; a++) m_mem[k][a] = IV;
            end else begin
                m_acc = 0;
                m_val = '0;
                m_err[k] = 0;
                m_rdy = (m_left[k] == 0);
                if (!m_rdy) begin
                    m_left[k]--;
                end else if (chip_en) begin
                    m_err[k] = (wr_en && int'(wr_addr) >= dep(k)) ||
                               (rd_en && int'(rd_addr) >= dep(k));
                    if (wr_en && int'(wr_addr) < dep(k) && !clr_req)
                        for (int b = 0; b < 4; b++)
                            if (wr_be[b]) m_mem[k][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                    if (rd_en && int'(rd_addr) < dep(k)) begin
                        m_acc = 1;
                        m_val = m_mem[k][rd_addr];
                    end
                end
                if (m_rdy && clr_req) begin
                    m_left[k] = dep(k);
                    for (int a = 0; a < 16; a++) m_mem[k][a] = IV;
                end
                if (lat(k) == 1) begin
                    m_v[k] = m_acc;
                    if (m_acc) m_d[k] = m_val;
                end else begin
                    m_v[k] = m_pv[k];
                    if (m_pv[k]) m_d[k] = m_pd[k];
                    m_pv[k] = m_acc;
                    if (m_acc) m_pd[k] = m_val;
                end
            end
        end
    end

    int cnt_valid [2] = '{0, 0};
    int cnt_err   [2] = '{0, 0};
    int cnt_busy  [2] = '{0, 0};

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy",  k, DW'(ibusy[k]),  DW'(m_left[k] > 0));
                chk("valid", k, DW'(rvalid[k]), DW'(m_v[k]));
                chk("err",   k, DW'(aerr[k]),   DW'(m_err[k]));
                chk("data",  k, rdata[k],       m_d[k]);
                if (rvalid[k]) cnt_valid[k]++;
                if (aerr[k])   cnt_err[k]++;
                if (ibusy[k])  cnt_busy[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chip_en = 1; clr_req = 0; wr_en = 0; rd_en = 0; wr_be = 4'h0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_be = be;
    endtask

    task automatic rd(input int a);
        rd_en = 1; rd_addr = AW'(a);
    endtask

    int base_v [2], base_e [2], base_b [2];

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            base_v[k] = cnt_valid[k]; base_e[k] = cnt_err[k]; base_b[k] = cnt_busy[k];
        end
    endtask

    initial begin
        wrst_n = 0; idle(); wr_addr = '0; rd_addr = '0; wr_data = '0;
        tick(); tick(); tick();
        started = 1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",  k, DW'(ibusy[k]),  DW'(1));
            chk("rst_valid", k, DW'(rvalid[k]), DW'(0));
            chk("rst_data",  k, rdata[k],       DW'(0));
            chk("rst_err",   k, DW'(aerr[k]),   DW'(0));
        end

        // Reset sweep, then read every address.
        wrst_n = 1; snap();
        repeat (20) tick();
        chk("sweep_len", 0, DW'(cnt_busy[0] - base_b[0]), DW'(16));
        chk("sweep_len", 1, DW'(cnt_busy[1] - base_b[1]), DW'(12));
        snap();
        for (int a = 0; a < 16; a++) begin rd(a); tick(); end
        idle(); repeat (3) tick();
        chk("sweep_reads", 0, DW'(cnt_valid[0] - base_v[0]), DW'(16));
        chk("sweep_reads", 1, DW'(cnt_valid[1] - base_v[1]), DW'(12));
        chk("sweep_oor",   0, DW'(cnt_err[0] - base_e[0]),   DW'(0));
        chk("sweep_oor",   1, DW'(cnt_err[1] - base_e[1]),   DW'(4));
        chk("sweep_val",   0, rdata[0], 32'hA5A5A5A5);
        chk("sweep_val",   1, rdata[1], 32'hA5A5A5A5);

        // Byte enables.
        wr(3, 32'h11223344, 4'hF); tick();
        wr(3, 32'hAABBCCDD, 4'b0101); tick();
        idle(); rd(3); tick();
        idle(); tick(); tick();
        chk("byte_en", 0, rdata[0], 32'h11BB33DD);
        chk("byte_en", 1, rdata[1], 32'h11BB33DD);

        // Collisions: full word and a single lane.
        wr(5, 32'h0, 4'hF); tick();
        wr(5, 32'h0000007E, 4'hF); rd(5); tick();
        idle(); tick(); tick();
        chk("collide", 0, rdata[0], 32'h0000007E);
        chk("collide", 1, rdata[1], 32'h0000007E);
        wr(5, 32'hFFFFFF11, 4'b0001); rd(5); tick();
        idle(); tick(); tick();
        chk("collide_lane", 0, rdata[0], 32'h00000011);
        chk("collide_lane", 1, rdata[1], 32'h00000011);

        // Back-to-back streaming through the two-stage pipe.
        for (int a = 0; a < 4; a++) begin wr(a, DW'(100 + a), 4'hF); tick(); end
        idle();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) rd(i); else rd_en = 0;
            tick();
            if (i >= 1 && i <= 4) begin
                chk("stream_v", 1, DW'(rvalid[1]), DW'(1));
                chk("stream_d", 1, rdata[1], DW'(100 + i - 1));
            end
        end
        idle(); tick();

        // Address 13 is out of range only for the 12-word instance.
        snap();
        wr(13, 32'h55, 4'hF); tick();
        idle(); rd(13); tick();
        idle(); tick(); tick();
        chk("oor_err",   1, DW'(cnt_err[1] - base_e[1]),   DW'(2));
        chk("oor_valid", 1, DW'(cnt_valid[1] - base_v[1]), DW'(0));
        chk("oor_err",   0, DW'(cnt_err[0] - base_e[0]),   DW'(0));
        chk("inr_data",  0, rdata[0], 32'h00000055);

        // clr_req, then reset at sweep cycle 5, with requests during INIT.
        clr_req = 1; tick();
        clr_req = 0; repeat (4) tick();
        wrst_n = 0; tick();
        wrst_n = 1; snap();
        wr(2, 32'hDEADBEEF, 4'hF); rd(14); tick();
        idle(); rd(2); tick();
        idle(); repeat (20) tick();
        chk("resweep_len", 0, DW'(cnt_busy[0] - base_b[0]),  DW'(16));
        chk("resweep_len", 1, DW'(cnt_busy[1] - base_b[1]),  DW'(12));
        chk("init_err",    0, DW'(cnt_err[0] - base_e[0]),   DW'(0));
        chk("init_err",    1, DW'(cnt_err[1] - base_e[1]),   DW'(0));
        chk("init_valid",  0, DW'(cnt_valid[0] - base_v[0]), DW'(0));
        rd(2); tick(); idle(); tick(); tick();
        chk("init_nowrite", 0, rdata[0], 32'hA5A5A5A5);
        chk("init_nowrite", 1, rdata[1], 32'hA5A5A5A5);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            wrst_n  = ($urandom_range(0, 399) != 0);
            chip_en = ($urandom_range(0, 7) != 0);
            clr_req = ($urandom_range(0, 79) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rd_en   = $urandom_range(0, 2) != 0;
            rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 15));
            tick();
        end
        wrst_n = 1; idle(); repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
